tb_snax_multiport_memory: RTL and testbench

Parametrised TCDM memory model for SNAX shell testbenches: serves `NumPorts` independent TCDM request/response channels over one shared word array. It supports configurable depth, data width, read latency, byte-strobe writes and pseudo-random backpressure. It sits beside the DUT in block-level benches and replaces single-port, fixed-latency dummy memories.

---
 rtl/tb_snax_mem_pkg.sv | 53 +++++
 rtl/tb_snax_mem_rsp_pipe.sv | 49 ++++
 rtl/tb_snax_multiport_memory.sv | 114 +++++++++++
 tb/tb_tb_snax_multiport_memory.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_snax_mem_pkg.sv
// Shared constants and helpers for the SNAX multi-port TCDM memory model.
// Holds LFSR stepping, latency bound, address shift and default bundles.
package tb_snax_mem_pkg;

   localparam int unsigned LfsrWidth = 16;
   // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR.
   localparam logic [LfsrWidth-1:0] LfsrTaps = 16'h002D;
   localparam int unsigned MaxReadLatency = 8;

   function automatic logic [LfsrWidth-1:0] lfsr_next(
      input logic [LfsrWidth-1:0] s
   );
      return {^(s & LfsrTaps), s[LfsrWidth-1:1]};
   endfunction

   function automatic logic [LfsrWidth-1:0] lfsr_seed(
      input logic [LfsrWidth-1:0] base,
      input int unsigned          port
   );
      logic [LfsrWidth-1:0] s;
      s = base ^ LfsrWidth'(port);
      return (s == '0) ? 16'h0001 : s;
   endfunction

   function automatic int unsigned addr_shift(
      input int unsigned data_width
   );
      return $clog2(data_width / 8);
   endfunction

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [63:0] data;
      logic [7:0]  strb;
   } tcdm_q_default_t;

   typedef struct packed {
      logic            q_valid;
      tcdm_q_default_t q;
   } tcdm_req_default_t;

   typedef struct packed {
      logic [63:0] data;
   } tcdm_p_default_t;

   typedef struct packed {
      logic            q_ready;
      logic            p_valid;
      tcdm_p_default_t p;
   } tcdm_rsp_default_t;

endpackage

// File: rtl/tb_snax_mem_rsp_pipe.sv
// Fixed-latency response pipeline for one TCDM port.
// Valid and data shift together; reset drops everything in flight.
module tb_snax_mem_rsp_pipe #(
   parameter int unsigned Latency   = 1,
   parameter int unsigned DataWidth = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 valid_o,
   output logic [DataWidth-1:0] data_o
);

   logic [Latency-1:0]   valid_q, valid_d;
   logic [DataWidth-1:0] data_q [Latency];
   logic [DataWidth-1:0] data_d [Latency];

   always_comb begin
      valid_d = '0;
      for (int unsigned s = 0; s < Latency; s++) begin
         data_d[s] = '0;
      end
      valid_d[0] = valid_i;
      data_d[0]  = data_i;
      for (int unsigned s = 1; s < Latency; s++) begin
         valid_d[s] = valid_q[s-1];
         data_d[s]  = data_q[s-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int unsigned s = 0; s < Latency; s++) begin
            data_q[s] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int unsigned s = 0; s < Latency; s++) begin
            data_q[s] <= data_d[s];
         end
      end
   end

   assign valid_o = valid_q[Latency-1];
   assign data_o  = data_q[Latency-1];

endmodule

// File: rtl/tb_snax_multiport_memory.sv
// Multi-port TCDM memory model with byte strobes, fixed read latency
// and per-port pseudo-random backpressure over one shared word array.
module tb_snax_multiport_memory
  import tb_snax_mem_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned Depth          = 1024,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned StallThreshold = 0,
  parameter logic [15:0] Seed           = 16'hACE1,
  parameter type tcdm_req_t             = tcdm_req_default_t,
  parameter type tcdm_rsp_t             = tcdm_rsp_default_t,
  parameter bit          ForceInitVal   = 1'b0,
  parameter string       InitVal        = "./mem/data/zero_dm.txt"
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  tcdm_req_t data_req_i [NumPorts],
  output tcdm_rsp_t data_rsp_o [NumPorts]
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffBits   = addr_shift(DataWidth);
  localparam int unsigned IdxWidth  =
    (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned Lat       =
    (ReadLatency < 1) ? 1 :
    (ReadLatency > MaxReadLatency) ? MaxReadLatency :
    ReadLatency;
  localparam logic [4:0] StallThr   = 5'(StallThreshold);

  logic [DataWidth-1:0] mem_q [Depth];

  logic                 started_q, started_d;
  logic [LfsrWidth-1:0] lfsr_q [NumPorts];
  logic [LfsrWidth-1:0] lfsr_d [NumPorts];

  logic [NumPorts-1:0]  ready;
  logic [NumPorts-1:0]  acc;
  logic [NumPorts-1:0]  wr_en;
  logic [NumPorts-1:0]  rsp_valid;
  logic [IdxWidth-1:0]  idx      [NumPorts];
  logic [DataWidth-1:0] pipe_in  [NumPorts];
  logic [DataWidth-1:0] pipe_out [NumPorts];

  always_comb begin
    started_d = 1'b1;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      lfsr_d[i]  = lfsr_next(lfsr_q[i]);
      ready[i]   = started_q &&
                   ({1'b0, lfsr_q[i][3:0]} >= StallThr);
      acc[i]     = data_req_i[i].q_valid && ready[i];
      wr_en[i]   = acc[i] && data_req_i[i].q.write;
      idx[i]     =
        IdxWidth'(data_req_i[i].q.addr >> OffBits);
      pipe_in[i] =
        (acc[i] && !data_req_i[i].q.write) ?
        mem_q[idx[i]] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started_q <= 1'b0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        lfsr_q[i] <= lfsr_seed(Seed, i);
      end
    end else begin
      started_q <= started_d;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        lfsr_q[i] <= lfsr_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (wr_en[i]) begin
        for (int unsigned b = 0; b < StrbWidth; b++) begin
          if (data_req_i[i].q.strb[b]) begin
            mem_q[idx[i]][b*8 +: 8] <=
              data_req_i[i].q.data[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NumPorts; g++) begin : g_port
    tb_snax_mem_rsp_pipe #(
      .Latency   (Lat),
      .DataWidth (DataWidth)
    ) u_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (acc[g]),
      .data_i  (pipe_in[g]),
      .valid_o (rsp_valid[g]),
      .data_o  (pipe_out[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      data_rsp_o[i]         = '0;
      data_rsp_o[i].q_ready = ready[i];
      data_rsp_o[i].p_valid = rsp_valid[i];
      data_rsp_o[i].p.data  = pipe_out[i];
    end
  end

endmodule

// File: tb/tb_tb_snax_multiport_memory.sv
// Bench for the multi-port TCDM memory model: four instances with
// different port counts, latencies and stall rates against one model.
module tb_tb_snax_multiport_memory;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [63:0] data;
      logic [7:0]  strb;
   } q_t;

   typedef struct packed {
      logic q_valid;
      q_t   q;
   } req_t;

   typedef struct packed {
      logic [63:0] data;
   } p_t;

   typedef struct packed {
      logic q_ready;
      logic p_valid;
      p_t   p;
   } rsp_t;

   typedef struct packed {
      int          due;
      logic [63:0] data;
      logic        known;
   } exp_t;

   localparam int NP [4] = '{3, 2, 2, 1};
   localparam int RL [4] = '{1, 3, 4, 1};
   localparam int ST [4] = '{0, 8, 0, 16};

   logic clk;
   logic rst_n [4];

   req_t rq [4][3];
   rsp_t rs [4][3];

   req_t req0 [3];
   req_t req1 [2];
   req_t req2 [2];
   req_t req3 [1];
   rsp_t rsp0 [3];
   rsp_t rsp1 [2];
   rsp_t rsp2 [2];
   rsp_t rsp3 [1];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   bit          started [4];
   logic [15:0] lf [4][3];
   exp_t        pend [12][$];
   logic [63:0] mm [int];
   logic [7:0]  mk [int];

   bit meas = 0;
   int st_cnt = 0;
   int st_tot = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int p = 0; p < 3; p++) req0[p] = rq[0][p];
      for (int p = 0; p < 2; p++) req1[p] = rq[1][p];
      for (int p = 0; p < 2; p++) req2[p] = rq[2][p];
      req3[0] = rq[3][0];
   end

   always_comb begin
      for (int k = 0; k < 4; k++)
         for (int p = 0; p < 3; p++) rs[k][p] = '0;
      for (int p = 0; p < 3; p++) rs[0][p] = rsp0[p];
      for (int p = 0; p < 2; p++) rs[1][p] = rsp1[p];
      for (int p = 0; p < 2; p++) rs[2][p] = rsp2[p];
      rs[3][0] = rsp3[0];
   end

   tb_snax_multiport_memory #(
      .NumPorts(3), .ReadLatency(1), .StallThreshold(0),
      .tcdm_req_t(req_t), .tcdm_rsp_t(rsp_t)
   ) u_a (
      .clk_i(clk), .rst_ni(rst_n[0]),
      .data_req_i(req0), .data_rsp_o(rsp0)
   );

   tb_snax_multiport_memory #(
      .NumPorts(2), .ReadLatency(3), .StallThreshold(8),
      .tcdm_req_t(req_t), .tcdm_rsp_t(rsp_t)
   ) u_b (
      .clk_i(clk), .rst_ni(rst_n[1]),
      .data_req_i(req1), .data_rsp_o(rsp1)
   );

   tb_snax_multiport_memory #(
      .NumPorts(2), .ReadLatency(4), .StallThreshold(0),
      .tcdm_req_t(req_t), .tcdm_rsp_t(rsp_t)
   ) u_c (
      .clk_i(clk), .rst_ni(rst_n[2]),
      .data_req_i(req2), .data_rsp_o(rsp2)
   );

   tb_snax_multiport_memory #(
      .NumPorts(1), .ReadLatency(1), .StallThreshold(16),
      .tcdm_req_t(req_t), .tcdm_rsp_t(rsp_t)
   ) u_d (
      .clk_i(clk), .rst_ni(rst_n[3]),
      .data_req_i(req3), .data_rsp_o(rsp3)
   );

   function automatic logic [15:0] step(logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   function automatic logic [15:0] seed_of(int p);
      logic [15:0] s;
      s = 16'hACE1 ^ 16'(p);
      return (s == 16'h0) ? 16'h1 : s;
   endfunction

   function automatic bit exp_ready(int k, int p);
      return started[k] && (int'(lf[k][p][3:0]) >= ST[k]);
   endfunction

   function automatic int key(int k, logic [31:0] a);
      return k * 1024 + int'((a >> 3) & 32'h3FF);
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set(int k, int p, logic w, logic [31:0] a,
                      logic [63:0] d, logic [7:0] s);
      rq[k][p].q_valid = 1'b1;
      rq[k][p].q.addr  = a;
      rq[k][p].q.write = w;
      rq[k][p].q.data  = d;
      rq[k][p].q.strb  = s;
   endtask

   task automatic clr(int k, int p);
      rq[k][p] = '0;
   endtask

   // Call at a negedge; returns at the negedge after acceptance.
   task automatic xfer(int k, int p, logic w, logic [31:0] a,
                       logic [63:0] d, logic [7:0] s);
      int n;
      n = 0;
      set(k, p, w, a, d, s);
      while (!rs[k][p].q_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("xfer_timeout", 64'd0, 64'd1);
      @(negedge clk);
      clr(k, p);
   endtask

   task automatic rand_reads(int p);
      logic [31:0] a;
      for (int n = 0; n < 100; n++) begin
         a = 32'($urandom_range(0, 31)) * 32'd8;
         xfer(1, p, 1'b0, a, 64'd0, 8'h00);
      end
   endtask

   // Reference model: acceptance, memory and expected responses.
   initial begin : model
      bit          acc [3];
      logic [63:0] rd  [3];
      logic        rk  [3];
      logic [63:0] w;
      logic [7:0]  wm;
      int          kk;
      forever begin
         @(posedge clk);
         for (int k = 0; k < 4; k++) begin
            if (!rst_n[k]) begin
               started[k] = 1'b0;
               for (int p = 0; p < 3; p++) begin
                  lf[k][p] = seed_of(p);
                  pend[k*3+p].delete();
               end
            end else begin
               for (int p = 0; p < 3; p++) begin
                  acc[p] = 1'b0;
                  rd[p]  = '0;
                  rk[p]  = 1'b0;
               end
               for (int p = 0; p < NP[k]; p++) begin
                  acc[p] = rq[k][p].q_valid && exp_ready(k, p);
                  kk = key(k, rq[k][p].q.addr);
                  if (mm.exists(kk)) begin
                     rd[p] = mm[kk];
                     rk[p] = (mk[kk] == 8'hFF);
                  end
               end
               for (int p = 0; p < NP[k]; p++) begin
                  if (acc[p] && rq[k][p].q.write) begin
                     kk = key(k, rq[k][p].q.addr);
                     w  = mm.exists(kk) ? mm[kk] : 64'd0;
                     wm = mk.exists(kk) ? mk[kk] : 8'd0;
                     for (int b = 0; b < 8; b++) begin
                        if (rq[k][p].q.strb[b]) begin
                           w[b*8 +: 8] = rq[k][p].q.data[b*8 +: 8];
                           wm[b] = 1'b1;
                        end
                     end
                     mm[kk] = w;
                     mk[kk] = wm;
                  end
               end
               for (int p = 0; p < NP[k]; p++) begin
                  if (acc[p]) begin
                     pend[k*3+p].push_back('{
                        due:   cyc + RL[k],
                        data:  rq[k][p].q.write ? 64'd0 : rd[p],
                        known: rq[k][p].q.write | rk[p]});
                  end
               end
               started[k] = 1'b1;
               for (int p = 0; p < 3; p++) lf[k][p] = step(lf[k][p]);
            end
         end
         cyc++;
      end
   end

   initial begin : compare
      exp_t e;
      bit   ev;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < NP[k]; p++) begin
               chk($sformatf("ready k%0d p%0d", k, p),
                   64'(rs[k][p].q_ready),
                   64'(rst_n[k] && exp_ready(k, p)));
               ev = rst_n[k] && pend[k*3+p].size() > 0 &&
                    pend[k*3+p][0].due == cyc;
               chk($sformatf("p_valid k%0d p%0d", k, p),
                   64'(rs[k][p].p_valid), 64'(ev));
               if (ev) begin
                  e = pend[k*3+p].pop_front();
                  if (e.known)
                     chk($sformatf("p_data k%0d p%0d", k, p),
                         rs[k][p].p.data, e.data);
               end
               if (k == 1 && meas && started[1]) begin
                  st_tot++;
                  if (!rs[1][p].q_ready) st_cnt++;
               end
            end
         end
      end
   end

   initial begin : stim
      int cnt;
      for (int k = 0; k < 4; k++) begin
         rst_n[k] = 1'b0;
         for (int p = 0; p < 3; p++) rq[k][p] = '0;
      end
      set(3, 0, 1'b0, 32'h0, 64'd0, 8'h00);

      chk("lfsr_pin0", step(16'hACE1), 16'h5670);
      chk("lfsr_pin1", step(16'h5670), 16'hAB38);

      @(negedge clk);
      chk("rst_ready", 64'(rs[0][0].q_ready), 64'd0);
      chk("rst_pvalid", 64'(rs[0][0].p_valid), 64'd0);
      chk("rst_pdata", rs[0][0].p.data, 64'd0);
      repeat (2) @(posedge clk);
      #2;
      for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;

      @(negedge clk);
      chk("warmup_ready_a", 64'(rs[0][0].q_ready), 64'd0);
      chk("warmup_ready_b", 64'(rs[1][0].q_ready), 64'd0);
      @(negedge clk);
      chk("cyc2_ready_a0", 64'(rs[0][0].q_ready), 64'd1);
      chk("cyc2_ready_a1", 64'(rs[0][1].q_ready), 64'd1);
      chk("cyc2_ready_b0", 64'(rs[1][0].q_ready), 64'd0);
      chk("cyc2_ready_b1", 64'(rs[1][1].q_ready), 64'd0);
      @(negedge clk);
      chk("cyc3_ready_b0", 64'(rs[1][0].q_ready), 64'd1);
      chk("cyc3_ready_b1", 64'(rs[1][1].q_ready), 64'd1);

      // Write on port 0 then read it back on port 1.
      set(0, 0, 1'b1, 32'h40, 64'hDEADBEEF_01234567, 8'hFF);
      @(negedge clk);
      clr(0, 0);
      set(0, 1, 1'b0, 32'h40, 64'd0, 8'h00);
      @(negedge clk);
      clr(0, 1);
      chk("wr_rd_valid", 64'(rs[0][1].p_valid), 64'd1);
      chk("wr_rd_data", rs[0][1].p.data, 64'hDEADBEEF_01234567);

      // Strobe merge.
      set(0, 0, 1'b1, 32'h100, 64'd0, 8'hFF);
      @(negedge clk);
      set(0, 0, 1'b1, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      @(negedge clk);
      set(0, 0, 1'b0, 32'h100, 64'd0, 8'h00);
      @(negedge clk);
      clr(0, 0);
      chk("strb_merge", rs[0][0].p.data, 64'h0000_0000_FFFF_FFFF);

      // Same-cycle write conflict with a concurrent reader.
      set(0, 0, 1'b1, 32'h8, {8{8'h33}}, 8'hFF);
      @(negedge clk);
      set(0, 0, 1'b1, 32'h8, {8{8'h11}}, 8'hFF);
      set(0, 1, 1'b1, 32'h8, {8{8'h22}}, 8'hFF);
      set(0, 2, 1'b0, 32'h8, 64'd0, 8'h00);
      @(negedge clk);
      clr(0, 1);
      clr(0, 2);
      set(0, 0, 1'b0, 32'h8, 64'd0, 8'h00);
      chk("conflict_old", rs[0][2].p.data, {8{8'h33}});
      @(negedge clk);
      clr(0, 0);
      chk("conflict_win", rs[0][0].p.data, {8{8'h22}});

      // Offset bits ignored and address wraps past Depth.
      set(0, 1, 1'b0, 32'h2047, 64'd0, 8'h00);
      @(negedge clk);
      clr(0, 1);
      chk("addr_wrap", rs[0][1].p.data, 64'hDEADBEEF_01234567);

      chk("always_stall", 64'(rs[3][0].q_ready), 64'd0);

      // Random reads through backpressure.
      for (int i = 0; i < 32; i++)
         xfer(1, 0, 1'b1, 32'(i * 8),
              {$urandom, $urandom}, 8'hFF);
      meas = 1'b1;
      fork
         rand_reads(0);
         rand_reads(1);
      join
      meas = 1'b0;
      repeat (6) @(negedge clk);
      chk("stall_rate",
          64'(st_tot > 0 && st_cnt * 100 >= 35 * st_tot &&
              st_cnt * 100 <= 65 * st_tot), 64'd1);

      // Reset while a read is in flight.
      xfer(2, 0, 1'b1, 32'h88, 64'hCAFEF00D_12345678, 8'hFF);
      xfer(2, 0, 1'b0, 32'h88, 64'd0, 8'h00);
      @(posedge clk);
      #2;
      rst_n[2] = 1'b0;
      @(negedge clk);
      chk("rst_drop_now", 64'(rs[2][0].p_valid), 64'd0);
      repeat (3) @(posedge clk);
      #2;
      rst_n[2] = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (rs[2][0].p_valid) cnt++;
      end
      chk("rst_no_pvalid", 64'(cnt), 64'd0);
      xfer(2, 0, 1'b0, 32'h88, 64'd0, 8'h00);
      cnt = 0;
      while (!rs[2][0].p_valid && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk("persist_valid", 64'(rs[2][0].p_valid), 64'd1);
      chk("persist_data", rs[2][0].p.data, 64'hCAFEF00D_12345678);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
